// File: rtl/vrx_pkg.sv
// Shared types for the video capture block: FSM states and pixel FIFO entry.
// Pixel index width follows the default horizontal + vertical counter widths.
package vrx_pkg;

   localparam int VRX_PIX_W = 12;
   localparam int VRX_IDX_W = 22;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_CAPTURE,
      ST_FLUSH
   } vrx_state_t;

   typedef struct packed {
      logic [VRX_PIX_W-1:0] pix;
      logic [VRX_IDX_W-1:0] idx;
   } vrx_entry_t;

endpackage

// File: rtl/vrx_sync_fifo.sv
// Single-clock pixel FIFO; a push into a full FIFO succeeds when a pop
// happens in the same cycle.
module vrx_sync_fifo
   import vrx_pkg::*;
#(
   parameter int pDepth = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  vrx_entry_t wdata,
   input  logic       pop,
   output vrx_entry_t rdata,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(pDepth);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;
   vrx_entry_t  mem [pDepth];

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/video_rx_capture.sv
// Video input capture to a UFI write bus through a pixel FIFO.
// Define VRX_DOUBLE_BUFFER_EN to alternate frame buffers after each frame.
module video_rx_capture
   import vrx_pkg::*;
#(
   parameter int pBusAdrsBit    = 32,
   parameter int pUfiBusWidth   = 12,
   parameter int pHdisplayWidth = 11,
   parameter int pVdisplayWidth = 11,
   parameter int pFifoDepth     = 16
) (
   input  logic                      iClk,
   input  logic                      iRst,
   input  logic [3:0]                iColorR,
   input  logic [3:0]                iColorG,
   input  logic [3:0]                iColorB,
   input  logic                      iHSync,
   input  logic                      iVSync,
   input  logic                      iDe,
   input  logic                      iEn,
   input  logic [pHdisplayWidth-1:0] iHdisplay,
   input  logic [pVdisplayWidth-1:0] iVdisplay,
   input  logic [pBusAdrsBit-1:0]    iBaseAdrs0,
   input  logic [pBusAdrsBit-1:0]    iBaseAdrs1,
   input  logic                      iStsClr,
   input  logic                      iMUfiRdy,
   output logic [pUfiBusWidth-1:0]   oMUfiWd,
   output logic [pBusAdrsBit-1:0]    oMUfiAdrs,
   output logic                      oMUfiWEd,
   output logic                      oMUfiVd,
   output logic                      oMUfiCmd,
   output logic                      oFrameDone,
   output logic                      oOverflow,
   output logic                      oFrameErr
);

   localparam int IDX_W = pHdisplayWidth + pVdisplayWidth;

   vrx_state_t                state;
   vrx_entry_t                pend_entry;
   vrx_entry_t                head;
   logic [IDX_W-1:0]          idx;
   logic [pHdisplayWidth-1:0] col;
   logic [pVdisplayWidth-1:0] line;
   logic [pBusAdrsBit-1:0]    base;
   logic vs_q, de_q, pend;
   logic frame_ok, frame_bad, buf_sel;
   logic frame_done, overflow, frame_err;
   logic full, empty, pop;
   logic ovf_evt, vs_fall, de_fall;

   assign vs_fall = vs_q & ~iVSync;
   assign de_fall = de_q & ~iDe;
   assign pop     = ~empty & iMUfiRdy;
   assign ovf_evt = pend & full & ~pop;

`ifdef VRX_DOUBLE_BUFFER_EN
   logic unused_ok;
   assign unused_ok = iHSync;
   assign base = buf_sel ? iBaseAdrs1 : iBaseAdrs0;
`else
   logic unused_ok;
   assign unused_ok = ^{iHSync, iBaseAdrs1, buf_sel};
   assign base = iBaseAdrs0;
`endif

   vrx_sync_fifo #(
      .pDepth (pFifoDepth)
   ) u_fifo (
      .clk   (iClk),
      .rst   (iRst),
      .push  (pend),
      .wdata (pend_entry),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state      <= ST_IDLE;
         vs_q       <= 1'b0;
         de_q       <= 1'b0;
         pend       <= 1'b0;
         pend_entry <= '0;
         idx        <= '0;
         col        <= '0;
         line       <= '0;
         frame_ok   <= 1'b0;
         frame_bad  <= 1'b0;
         buf_sel    <= 1'b0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         vs_q       <= iVSync;
         de_q       <= iDe;
         pend       <= 1'b0;
         frame_done <= 1'b0;
         if (iStsClr) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
         end
         unique case (state)
            ST_IDLE: begin
               if (iEn) state <= ST_ARMED;
            end
            ST_ARMED: begin
               idx       <= '0;
               col       <= '0;
               line      <= '0;
               frame_ok  <= 1'b0;
               frame_bad <= 1'b0;
               if (vs_fall) state <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               if (!iEn) begin
                  state <= ST_FLUSH;
               end else if (vs_fall) begin
                  frame_err <= 1'b1;
                  frame_bad <= 1'b1;
                  state     <= ST_FLUSH;
               end else begin
                  if (iDe) begin
                     pend           <= 1'b1;
                     pend_entry.pix <= {iColorR, iColorG, iColorB};
                     pend_entry.idx <= VRX_IDX_W'(idx);
                     idx            <= idx + 1'b1;
                     col            <= col + 1'b1;
                  end
                  if (de_fall) begin
                     line <= line + 1'b1;
                     col  <= '0;
                     if (col != iHdisplay) begin
                        frame_err <= 1'b1;
                        frame_bad <= 1'b1;
                     end
                     if ((line + 1'b1) == iVdisplay) begin
                        frame_ok <= 1'b1;
                        state    <= ST_FLUSH;
                     end
                  end
               end
            end
            ST_FLUSH: begin
               if (empty && !pend) begin
                  state <= ST_IDLE;
                  if (frame_ok && !frame_bad) begin
                     frame_done <= 1'b1;
`ifdef VRX_DOUBLE_BUFFER_EN
                     buf_sel <= ~buf_sel;
`endif
                  end
               end
            end
         endcase
         // a dropped pixel still consumed its index when it was registered
         if (ovf_evt) begin
            overflow  <= 1'b1;
            frame_bad <= 1'b1;
         end
      end
   end

   assign oMUfiWEd   = pop;
   assign oMUfiWd    = pop ? pUfiBusWidth'(head.pix) : '0;
   assign oMUfiAdrs  = pop ? base + pBusAdrsBit'(head.idx) : '0;
   assign oMUfiVd    = (state == ST_CAPTURE) || (state == ST_FLUSH);
   assign oMUfiCmd   = 1'b0;
   assign oFrameDone = frame_done;
   assign oOverflow  = overflow;
   assign oFrameErr  = frame_err;

endmodule

// File: doc/video_rx_capture.md
VIDEO_RX_CAPTURE -- requirements
Module: video_rx_capture

Interface
REQ-001 SHALL have parameter pBusAdrsBit, default 32: UFI address width.
REQ-002 SHALL have parameter pUfiBusWidth, default 12: UFI data width (RGB444 pixel).
REQ-003 SHALL have parameter pHdisplayWidth, default 11: horizontal counter width.
REQ-004 SHALL have parameter pVdisplayWidth, default 11: vertical counter width.
REQ-005 SHALL have parameter pFifoDepth, default 16: pixel FIFO entries, power of two.
REQ-006 SHALL have ports (clock and reset first):
- iClk  in  1  single clock; all logic on rising edge.
- iRst  in  1  reset, synchronous, active-high.
- iColorR/iColorG/iColorB  in  4 each  pixel colour.
- iHSync / iVSync  in  1  sync inputs, active-low.
- iDe  in  1  pixel valid.
- iEn  in  1  capture enable.
- iHdisplay / iVdisplay  in  pHdisplayWidth / pVdisplayWidth  active size.
- iBaseAdrs0 / iBaseAdrs1  in  pBusAdrsBit  frame buffer bases.
- iStsClr  in  1  clears sticky status.
- iMUfiRdy  in  1  bus ready.
- oMUfiWd  out  pUfiBusWidth  write data {R,G,B}.
- oMUfiAdrs  out  pBusAdrsBit  write address.
- oMUfiWEd  out  1  write beat strobe.
- oMUfiVd  out  1  transfer period.
- oMUfiCmd  out  1  constant 0 (write).
- oFrameDone  out  1  one-cycle pulse per complete frame.
- oOverflow / oFrameErr  out  1  sticky status.

Function
REQ-007 SHALL implement FSM IDLE -> ARMED -> CAPTURE -> FLUSH -> IDLE.
REQ-008 IDLE: leaves to ARMED when iEn=1.
REQ-009 ARMED: leaves to CAPTURE on the iVSync falling edge (registered 1->0); pixel index, line and column counters clear.
REQ-010 CAPTURE: each iDe=1 cycle pushes {pixel, index} into the FIFO one cycle later (input register stage); index increments per accepted or dropped pixel.
REQ-011 Line end: an iDe falling edge increments the line counter; a column count != iHdisplay sets oFrameErr.
REQ-012 Line counter reaching iVdisplay -> FLUSH.
REQ-013 A new iVSync falling edge in CAPTURE -> oFrameErr=1, FLUSH.
REQ-014 iEn=0 in CAPTURE -> FLUSH; remaining pixels are not pushed.
REQ-015 FLUSH: waits for FIFO empty, then IDLE. oFrameDone pulses only if the frame ended by REQ-012 with no error set during this frame.
REQ-016 Drain: the FIFO pops when non-empty and iMUfiRdy=1. Pop cycle: oMUfiWEd=1, oMUfiWd=pixel, oMUfiAdrs=base+index.
REQ-017 Minimum latency: iDe sample at cycle N -> oMUfiWEd at cycle N+2.
REQ-018 FIFO full with a push pending and no pop in the same cycle -> pixel dropped, index still increments, oOverflow=1.
REQ-019 Push and pop in the same cycle while full -> both succeed, no overflow.
REQ-020 Index width = pHdisplayWidth+pVdisplayWidth; base+index add is unsigned, modulo 2^pBusAdrsBit.
REQ-021 oMUfiVd=1 in CAPTURE and FLUSH.
REQ-022 iStsClr=1 clears oOverflow/oFrameErr; a set event in the same cycle wins.

Reset
REQ-023 iRst=1 -> state IDLE, FIFO empty, counters 0, all outputs 0, buffer select 0; valid mid-frame, no pending beats issued.

Configuration
REQ-024 Macro VRX_DOUBLE_BUFFER_EN defined: base alternates iBaseAdrs0/iBaseAdrs1, toggling after each oFrameDone. Undefined: base is always iBaseAdrs0 and iBaseAdrs1 is ignored.

Structure
REQ-025 Package vrx_pkg SHALL hold the FSM state enum, the FIFO entry struct and the index-width constant.
REQ-026 Sub-module vrx_sync_fifo (single-clock, full/empty, simultaneous push/pop) SHALL be instantiated once.

Verification
REQ-027 iHdisplay=8, iVdisplay=4, iMUfiRdy=1 -> 32 beats at addresses 0x100..0x11F (iBaseAdrs0=0x100), pixel data matches the input, oFrameDone once.
REQ-028 iMUfiRdy=0 for 40 cycles during a line with pFifoDepth=16 -> oOverflow=1; surviving beats keep correct addresses; no oFrameDone.
REQ-029 Line 2 carries only 7 DE cycles -> oFrameErr=1, no oFrameDone; iStsClr -> 0.
REQ-030 iRst pulsed mid-line 2 -> all outputs 0 next cycle; the next frame captures cleanly from index 0.
REQ-031 With VRX_DOUBLE_BUFFER_EN, two frames -> frame 1 at iBaseAdrs0, frame 2 at iBaseAdrs1; without it, both at iBaseAdrs0.
REQ-032 A second iVSync falling edge at line 2 -> oFrameErr=1, FLUSH drains the FIFO, then ARMED for the next frame.
